cic_decim_ctrl: RTL and testbench
=================================

// Module: cic_decim_ctrl
// PURPOSE
// - Rate scheduler for the CIC decimator comb cascade: counts integrator-rate sample strobes and issues one
//   comb clock-enable per R input samples. Blanks comb outputs until delay lines hold real data.
// - Sits between the integrator section (i_in_valid) and the comb chain (drives every comb i_ce).
// - Runtime-programmable decimation ratio, applied only on a decimation-phase boundary.
// PARAMETERS
// - RATE_W       16  width of ratio, phase counter and rate ports
// - DEFAULT_RATE 8   ratio R loaded at reset (must be >= MIN_RATE)
// - MIN_RATE     2   smallest legal R; smaller loads are rejected
// - STAGES       3   number of comb stages in the cascade
// - DIFF_DELAY   1   differential delay N of each comb stage
// - Derived: WARMUP = STAGES*(DIFF_DELAY+1) comb strobes discarded after each (re)start
// PORTS
// - i_clk        in  1       clock, all logic on rising edge
// - i_reset      in  1       synchronous, active-high reset
// - i_enable     in  1       1 = run, 0 = stop and clear sequencing
// - i_in_valid   in  1       one-cycle strobe per integrator output sample
// - i_rate       in  RATE_W  new decimation ratio R
// - i_rate_load  in  1       strobe: capture i_rate
// - o_comb_ce    out 1       one-cycle enable to all comb stages
// - o_out_valid  out 1       comb cascade output is valid this cycle
// - o_state      out 2       00 IDLE, 01 FILL, 10 RUN
// - o_rate       out RATE_W  ratio currently in effect
// - o_phase      out RATE_W  input-sample phase counter, 0..R-1
// - o_rate_err   out 1       sticky illegal-rate flag (CIC_CTRL_ERR_EN only)
// BEHAVIOUR
// - Reset: o_comb_ce=0, o_out_valid=0, o_state=IDLE, o_rate=DEFAULT_RATE, o_phase=0, pending rate empty,
//   warm-up count 0, o_rate_err=0. Reset mid-operation aborts everything with no extra strobes.
// - IDLE: i_in_valid ignored, phase held at 0. i_enable=1 -> FILL next cycle, warm-up count=0.
// - Any state with i_enable=0 -> IDLE next cycle, phase=0, warm-up count=0, no o_comb_ce/o_out_valid issued.
//   o_rate and the pending rate are kept.
// - Phase: on i_in_valid in FILL/RUN, phase++; wrap when phase==R-1 -> phase=0 and o_comb_ce=1 the next cycle
//   (registered, exactly one cycle wide). No i_in_valid -> no phase change.
// - FILL: counts issued o_comb_ce strobes. The WARMUP-th strobe moves state to RUN; that strobe itself is not valid.
// - o_out_valid = 1 exactly one cycle after each o_comb_ce issued while in RUN. This matches the one-cycle comb
//   output register. The first valid output comes from the (WARMUP+1)-th strobe.
// - Rate load: a legal i_rate (>=MIN_RATE) becomes pending; a later load overwrites an unapplied pending value.
//   - IDLE: applied immediately (o_rate updates next cycle).
//   - FILL/RUN: applied on the next phase wrap. The strobe for that wrap is still issued. The state then goes
//     to FILL and the warm-up count clears.
//   - Load coinciding with a wrap: the new value applies at that wrap.
//   - Illegal load (<MIN_RATE): ignored; pending and o_rate unchanged.
// - i_rate_load and i_enable falling in the same cycle: load captured, applied later per IDLE rule.
// - Back-to-back i_in_valid every cycle is legal. With R=MIN_RATE, o_comb_ce pulses every 2nd cycle.
// CONFIGURATION
// - CIC_CTRL_ERR_EN defined: o_rate_err is set on any illegal load and held until i_reset.
// - CIC_CTRL_ERR_EN undefined: o_rate_err port removed; illegal loads silently ignored.
//   All other behaviour is identical.
// TESTING
// - Reset, enable, R=8, STAGES=3, DIFF_DELAY=1, i_in_valid every cycle -> o_comb_ce every 8th cycle.
//   First 6 strobes have no o_out_valid; from the 7th, o_out_valid follows each strobe by 1 cycle.
// - i_in_valid every 3rd cycle, R=4 -> o_comb_ce every 12 cycles; o_phase steps 0,1,2,3,0.
// - RUN with R=8, load R=5 at phase 2 -> wrap at 7 uses 8, then 5-sample spacing, state=FILL.
//   o_out_valid stays 0 for 6 strobes.
// - Load R=1 -> o_rate stays 8; o_rate_err=1 with CIC_CTRL_ERR_EN, port absent without.
// - Drop i_enable mid-phase (phase=5) -> IDLE next cycle, phase=0, no further strobes.
//   Re-enable -> full 6-strobe warm-up again.
// - Assert i_reset during RUN with strobe due next cycle -> no strobe; all outputs at reset values;
//   o_rate=DEFAULT_RATE.

Source files
------------

// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: rate scheduler for the CIC decimator comb cascade.
// Counts integrator-rate input strobes. Issues one comb clock-enable per R
// samples. Blanks comb outputs until the comb delay lines hold real data.
// The ratio R is programmable at runtime. A new ratio takes effect on a
// decimation-phase boundary.
// Optional feature macro: CIC_CTRL_ERR_EN adds the sticky o_rate_err flag,
// which is set when a load below MIN_RATE is attempted.
module cic_decim_ctrl #(
    parameter int unsigned RATE_W       = 16,
    parameter int unsigned DEFAULT_RATE = 8,
    parameter int unsigned MIN_RATE     = 2,
    parameter int unsigned STAGES       = 3,
    parameter int unsigned DIFF_DELAY   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_in_valid,
    input  logic [RATE_W-1:0] i_rate,
    input  logic              i_rate_load,
    output logic              o_comb_ce,
    output logic              o_out_valid,
    output logic [1:0]        o_state,
    output logic [RATE_W-1:0] o_rate,
    output logic [RATE_W-1:0] o_phase
`ifdef CIC_CTRL_ERR_EN
    ,
    output logic              o_rate_err
`endif
);

    localparam int unsigned WARMUP = STAGES * (DIFF_DELAY + 1);
    localparam int unsigned WARM_W = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [RATE_W-1:0]   phase_q, phase_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic [RATE_W-1:0]   pend_rate_q, pend_rate_d;
    logic                pend_vld_q, pend_vld_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic                ce_q, ce_d;
    logic                ce_run_q, ce_run_d;
    logic                out_valid_q, out_valid_d;

    logic                load_ok_c;
    logic                wrap_c;
    logic                apply_c;
    logic [RATE_W-1:0]   new_rate_c;

    // Decode of this cycle's phase wrap and rate-load qualification
    always_comb begin
        load_ok_c  = i_rate_load && (i_rate >= RATE_W'(MIN_RATE));
        wrap_c     = (state_q != ST_IDLE) && i_enable && i_in_valid &&
                     (phase_q == rate_q - RATE_W'(1));
        apply_c    = wrap_c && (load_ok_c || pend_vld_q);
        new_rate_c = load_ok_c ? i_rate : pend_rate_q;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: warm-up completion and rate-change restarts
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FILL;
                ST_FILL: begin
                    if (wrap_c && !apply_c && (warm_q == WARM_W'(WARMUP - 1))) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (apply_c) begin
                        state_d = ST_FILL;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values: phase, strobes, warm-up count, ratio
    always_comb begin
        phase_d     = phase_q;
        warm_d      = warm_q;
        rate_d      = rate_q;
        pend_rate_d = pend_rate_q;
        pend_vld_d  = pend_vld_q;
        ce_d        = 1'b0;
        ce_run_d    = 1'b0;
        // A strobe issued in RUN produces a valid comb output one cycle later
        out_valid_d = i_enable && ce_q && ce_run_q;

        if (state_q == ST_IDLE) begin
            phase_d = '0;
            warm_d  = '0;
            if (load_ok_c) begin
                rate_d     = i_rate;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                rate_d     = pend_rate_q;
                pend_vld_d = 1'b0;
            end
        end else if (!i_enable) begin
            phase_d = '0;
            warm_d  = '0;
            if (load_ok_c) begin
                pend_rate_d = i_rate;
                pend_vld_d  = 1'b1;
            end
        end else begin
            if (i_in_valid) begin
                phase_d = wrap_c ? '0 : phase_q + RATE_W'(1);
            end
            if (wrap_c) begin
                ce_d     = 1'b1;
                ce_run_d = (state_q == ST_RUN);
                if (apply_c) begin
                    rate_d     = new_rate_c;
                    pend_vld_d = 1'b0;
                    warm_d     = '0;
                end else if (state_q == ST_FILL) begin
                    warm_d = warm_q + WARM_W'(1);
                end
            end else if (load_ok_c) begin
                pend_rate_d = i_rate;
                pend_vld_d  = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            phase_q     <= '0;
            warm_q      <= '0;
            rate_q      <= RATE_W'(DEFAULT_RATE);
            pend_rate_q <= '0;
            pend_vld_q  <= 1'b0;
            ce_q        <= 1'b0;
            ce_run_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            warm_q      <= warm_d;
            rate_q      <= rate_d;
            pend_rate_q <= pend_rate_d;
            pend_vld_q  <= pend_vld_d;
            ce_q        <= ce_d;
            ce_run_q    <= ce_run_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef CIC_CTRL_ERR_EN
    logic rate_err_q;

    // Sticky flag for any rejected ratio load, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rate_err_q <= 1'b0;
        end else if (i_rate_load && (i_rate < RATE_W'(MIN_RATE))) begin
            rate_err_q <= 1'b1;
        end
    end

    assign o_rate_err = rate_err_q;
`endif

    assign o_comb_ce   = ce_q;
    assign o_out_valid = out_valid_q;
    assign o_state     = state_q;
    assign o_rate      = rate_q;
    assign o_phase     = phase_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl: a directed vector table, scenario
// sequences and random stimulus. All three are compared against a
// sample/strobe-counting reference model.
module tb_cic_decim_ctrl;

    localparam int unsigned RATE_W = 16;
    localparam int DEF_RATE = 8;
    localparam int MIN_RATE = 2;
    localparam int WARMUP   = 6;

    logic              clk = 1'b0;
    logic              reset, en, iv, load;
    logic [RATE_W-1:0] rate_in;
    logic              o_comb_ce, o_out_valid;
    logic [1:0]        o_state;
    logic [RATE_W-1:0] o_rate, o_phase;
`ifdef CIC_CTRL_ERR_EN
    logic              o_rate_err;
`endif

    always #5 clk = ~clk;

    cic_decim_ctrl dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (en),
        .i_in_valid  (iv),
        .i_rate      (rate_in),
        .i_rate_load (load),
        .o_comb_ce   (o_comb_ce),
        .o_out_valid (o_out_valid),
        .o_state     (o_state),
        .o_rate      (o_rate),
        .o_phase     (o_phase)
`ifdef CIC_CTRL_ERR_EN
        ,
        .o_rate_err  (o_rate_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: sample counting per decimation period, strobe counting since restart
    int m_active, m_phase, m_rate, m_pend, m_strobes;
    int m_ce, m_cev, m_ov, m_err;

    function automatic int m_state();
        if (m_active == 0) return 0;
        return (m_strobes >= WARMUP) ? 2 : 1;
    endfunction

    task automatic model_step();
        int  n_ce;
        int  n_cev;
        int  n_ov;
        bit  legal;
        int  r;
        n_ce  = 0;
        n_cev = 0;
        r     = int'(rate_in);
        if (reset) begin
            m_active = 0; m_phase = 0; m_rate = DEF_RATE; m_pend = -1; m_strobes = 0;
            m_ce = 0; m_cev = 0; m_ov = 0; m_err = 0;
            return;
        end
        legal = load && (r >= MIN_RATE);
        if (load && !legal) m_err = 1;
        n_ov = (en && m_ce != 0 && m_cev != 0) ? 1 : 0;
        if (m_active == 0) begin
            if (legal) begin
                m_rate = r; m_pend = -1;
            end else if (m_pend >= 0) begin
                m_rate = m_pend; m_pend = -1;
            end
            m_phase = 0; m_strobes = 0; m_active = en ? 1 : 0;
        end else if (!en) begin
            if (legal) m_pend = r;
            m_active = 0; m_phase = 0; m_strobes = 0;
        end else if (iv && m_phase == m_rate - 1) begin
            n_ce    = 1;
            n_cev   = (m_strobes >= WARMUP) ? 1 : 0;
            m_phase = 0;
            if (legal) begin
                m_rate = r; m_pend = -1; m_strobes = 0;
            end else if (m_pend >= 0) begin
                m_rate = m_pend; m_pend = -1; m_strobes = 0;
            end else begin
                m_strobes++;
            end
        end else begin
            if (iv) m_phase++;
            if (legal) m_pend = r;
        end
        m_ce = n_ce; m_cev = n_cev; m_ov = n_ov;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs, clock, then compare the DUT against the model
    task automatic cycle(input bit r, input bit e, input bit v, input bit l, input int rv);
        reset   = r;
        en      = e;
        iv      = v;
        load    = l;
        rate_in = RATE_W'(rv);
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        chk("model_comb_ce",   32'(o_comb_ce),   32'(m_ce));
        chk("model_out_valid", 32'(o_out_valid), 32'(m_ov));
        chk("model_state",     32'(o_state),     32'(m_state()));
        chk("model_rate",      32'(o_rate),      32'(m_rate));
        chk("model_phase",     32'(o_phase),     32'(m_phase));
`ifdef CIC_CTRL_ERR_EN
        chk("model_rate_err",  32'(o_rate_err),  32'(m_err));
`endif
    endtask

    typedef struct {
        bit rst, en, iv, ld;
        int rate;
        bit ce, ov;
        int st, orate, ph;
    } vec_t;

    vec_t vt[10];

    initial begin
        int last, nce, nov, k;
        bit first_ov, prev_ce;

        reset = 1'b1; en = 1'b0; iv = 1'b0; load = 1'b0; rate_in = '0;

        // Directed vectors: R=2 back-to-back samples, illegal load, disable
        vt[0] = '{1,0,0,0,0, 0,0, 0,8,0};
        vt[1] = '{0,0,0,1,2, 0,0, 0,2,0};
        vt[2] = '{0,1,1,0,0, 0,0, 1,2,0};
        vt[3] = '{0,1,1,0,0, 0,0, 1,2,1};
        vt[4] = '{0,1,1,0,0, 1,0, 1,2,0};
        vt[5] = '{0,1,1,0,0, 0,0, 1,2,1};
        vt[6] = '{0,1,1,0,0, 1,0, 1,2,0};
        vt[7] = '{0,1,0,0,0, 0,0, 1,2,0};
        vt[8] = '{0,1,0,1,1, 0,0, 1,2,0};
        vt[9] = '{0,0,0,0,0, 0,0, 0,2,0};
        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].rst, vt[i].en, vt[i].iv, vt[i].ld, vt[i].rate);
            chk($sformatf("vec%0d_comb_ce", i),   32'(o_comb_ce),   32'(vt[i].ce));
            chk($sformatf("vec%0d_out_valid", i), 32'(o_out_valid), 32'(vt[i].ov));
            chk($sformatf("vec%0d_state", i),     32'(o_state),     32'(vt[i].st));
            chk($sformatf("vec%0d_rate", i),      32'(o_rate),      32'(vt[i].orate));
            chk($sformatf("vec%0d_phase", i),     32'(o_phase),     32'(vt[i].ph));
        end
`ifdef CIC_CTRL_ERR_EN
        chk("vec_rate_err_sticky", 32'(o_rate_err), 32'd1);
`endif

        // R=8, sample every cycle: strobe every 8 cycles, first valid after 7th strobe
        cycle(1,0,0,0,0);
        last = -1; nce = 0; first_ov = 0; prev_ce = 0;
        for (int i = 0; i < 100; i++) begin
            cycle(0,1,1,0,0);
            if (o_comb_ce) begin
                if (last >= 0) chk("s1_ce_spacing", 32'(cyc - last), 32'd8);
                last = cyc; nce++;
            end
            if (o_out_valid && !first_ov) begin
                first_ov = 1;
                chk("s1_first_valid_strobe", 32'(nce), 32'd7);
                chk("s1_valid_lag", 32'(prev_ce), 32'd1);
            end
            prev_ce = o_comb_ce;
        end
        chk("s1_saw_valid", 32'(first_ov), 32'd1);
        chk("s1_state_run", 32'(o_state), 32'd2);

        // Rate change in RUN: load 5 at phase 2, wrap at 7 still uses 8
        k = 0;
        while (o_phase != 2 && k < 20) begin cycle(0,1,1,0,0); k++; end
        chk("s3_reach_phase2", 32'(o_phase), 32'd2);
        cycle(0,1,1,1,5);
        chk("s3_rate_pending", 32'(o_rate), 32'd8);
        k = 0;
        while (!o_comb_ce && k < 20) begin cycle(0,1,1,0,0); k++; end
        chk("s3_old_rate_wrap", 32'(k), 32'd5);
        chk("s3_rate_applied", 32'(o_rate), 32'd5);
        chk("s3_state_fill", 32'(o_state), 32'd1);
        last = cyc;
        cycle(0,1,1,0,0);
        nce = 0; nov = 0; k = 0;
        while (nce < 6 && k < 100) begin
            cycle(0,1,1,0,0); k++;
            if (o_out_valid) nov++;
            if (o_comb_ce) begin
                chk("s3_new_spacing", 32'(cyc - last), 32'd5);
                last = cyc; nce++;
            end
        end
        chk("s3_warmup_strobes", 32'(nce), 32'd6);
        cycle(0,1,1,0,0);
        if (o_out_valid) nov++;
        chk("s3_no_valid_in_warmup", 32'(nov), 32'd0);
        k = 0;
        while (!o_comb_ce && k < 20) begin cycle(0,1,1,0,0); k++; end
        cycle(0,1,1,0,0);
        chk("s3_valid_after_7th", 32'(o_out_valid), 32'd1);

        // R=4, one sample every 3rd cycle: strobe every 12 cycles
        cycle(0,0,0,1,4);
        cycle(0,0,0,0,0);
        chk("s2_rate_idle_apply", 32'(o_rate), 32'd4);
        last = -1;
        for (int i = 0; i < 120; i++) begin
            cycle(0,1,(i % 3 == 0),0,0);
            if (o_comb_ce) begin
                if (last >= 0) chk("s2_ce_spacing", 32'(cyc - last), 32'd12);
                last = cyc;
            end
        end

        // Illegal ratio load is rejected
        cycle(0,1,0,1,1);
        chk("s4_illegal_rate_kept", 32'(o_rate), 32'd4);
`ifdef CIC_CTRL_ERR_EN
        chk("s4_rate_err_set", 32'(o_rate_err), 32'd1);
`endif

        // Drop enable at phase 5, then re-enable for a full warm-up
        cycle(0,0,0,1,8);
        cycle(0,0,0,0,0);
        cycle(0,1,0,0,0);
        k = 0;
        while (o_phase != 5 && k < 20) begin cycle(0,1,1,0,0); k++; end
        chk("s5_reach_phase5", 32'(o_phase), 32'd5);
        cycle(0,0,1,0,0);
        chk("s5_idle_state", 32'(o_state), 32'd0);
        chk("s5_idle_phase", 32'(o_phase), 32'd0);
        nce = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0,0,1,0,0);
            if (o_comb_ce) nce++;
        end
        chk("s5_no_strobe_idle", 32'(nce), 32'd0);
        nce = 0; first_ov = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(0,1,1,0,0);
            if (o_comb_ce) nce++;
            if (o_out_valid && !first_ov) begin
                first_ov = 1;
                chk("s5_rewarm_first_valid", 32'(nce), 32'd7);
            end
        end
        chk("s5_saw_valid", 32'(first_ov), 32'd1);

        // Reset in RUN with a strobe due next cycle, non-default ratio
        cycle(0,0,0,1,6);
        cycle(0,0,0,0,0);
        k = 0;
        while (o_state != 2 && k < 200) begin cycle(0,1,1,0,0); k++; end
        chk("s6_reach_run", 32'(o_state), 32'd2);
        k = 0;
        while (o_phase != 5 && k < 10) begin cycle(0,1,1,0,0); k++; end
        chk("s6_reach_phase5", 32'(o_phase), 32'd5);
        cycle(1,1,1,0,0);
        chk("s6_reset_no_ce", 32'(o_comb_ce), 32'd0);
        chk("s6_reset_no_valid", 32'(o_out_valid), 32'd0);
        chk("s6_reset_state", 32'(o_state), 32'd0);
        chk("s6_reset_rate", 32'(o_rate), 32'(DEF_RATE));
        chk("s6_reset_phase", 32'(o_phase), 32'd0);
`ifdef CIC_CTRL_ERR_EN
        chk("s6_reset_err", 32'(o_rate_err), 32'd0);
`endif
        cycle(0,0,0,0,0);
        chk("s6_post_reset_no_ce", 32'(o_comb_ce), 32'd0);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 29) == 0),
                  int'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
